// File: rtl/aes_pkg.sv
// AES-128 key-schedule constants shared by the key-expansion top and its helpers.
package aes_pkg;

    // Width of one round key and of one 32-bit schedule word.
    localparam int KEY_W      = 128;
    localparam int WORD_W     = 32;

    // AES-128 performs ten rounds, so eleven round keys (0..10) exist.
    localparam int NUM_ROUNDS = 10;

    // Round constants; element r is the leading byte XORed into round r.
    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef logic [KEY_W-1:0]  roundKey_t;
    typedef logic [WORD_W-1:0] keyWord_t;

endpackage

// File: rtl/aes_key_generation_if.sv
// Bundle of the cipher key and the eleven parallel round keys.
// The key producer drives inputKey; the expansion side returns roundKey.
interface aes_key_generation_if;
    import aes_pkg::*;

    logic [KEY_W-1:0]                  inputKey;
    logic [NUM_ROUNDS:0][KEY_W-1:0]    roundKey;

    modport master (output inputKey, input  roundKey);
    modport slave  (input  inputKey, output roundKey);

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box: 256-entry byte substitution ROM, purely combinational.
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Entry 0 is the leftmost byte, so the table reads row by row 00..ff.
    localparam logic [0:255][7:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign data_o = SBOX_ROM[data_i];

endmodule

// File: rtl/aes_key_generation.sv
// AES-128 key expansion: all eleven round keys are derived combinationally
// from the incoming cipher key and captured together on one clock edge,
// giving a fixed single-cycle latency with no handshake.
module aes_key_generation
    import aes_pkg::*;
(
    input  logic             i_aes_key_generation_clk,
    input  logic             i_aes_key_generation_rst_n,
    input  logic [KEY_W-1:0] i_aes_key_generation_input_key,
    output logic [KEY_W-1:0] o_aes_key_generation_key_0,
    output logic [KEY_W-1:0] o_aes_key_generation_key_1,
    output logic [KEY_W-1:0] o_aes_key_generation_key_2,
    output logic [KEY_W-1:0] o_aes_key_generation_key_3,
    output logic [KEY_W-1:0] o_aes_key_generation_key_4,
    output logic [KEY_W-1:0] o_aes_key_generation_key_5,
    output logic [KEY_W-1:0] o_aes_key_generation_key_6,
    output logic [KEY_W-1:0] o_aes_key_generation_key_7,
    output logic [KEY_W-1:0] o_aes_key_generation_key_8,
    output logic [KEY_W-1:0] o_aes_key_generation_key_9,
    output logic [KEY_W-1:0] o_aes_key_generation_key_10
);

    // Combinational schedule (next state) and the registered copy (outputs).
    roundKey_t roundKey_d [0:NUM_ROUNDS];
    roundKey_t roundKey_q [0:NUM_ROUNDS];

    assign roundKey_d[0] = i_aes_key_generation_input_key;

    // Each round derives its four words from the previous round's words;
    // the rounds are chained, so the input key ripples through all ten.
    for (genvar r = 1; r <= NUM_ROUNDS; r++) begin : g_round
        keyWord_t w0, w1, w2, w3;
        keyWord_t rotWord, subWord, tWord;
        keyWord_t n0, n1, n2, n3;

        assign {w0, w1, w2, w3} = roundKey_d[r-1];
        assign rotWord = {w3[23:0], w3[31:24]};

        for (genvar b = 0; b < 4; b++) begin : g_sbox
            aes_sbox u_sbox (
                .data_i (rotWord[8*b +: 8]),
                .data_o (subWord[8*b +: 8])
            );
        end

        assign tWord = subWord ^ {RCON[r], 24'h000000};
        assign n0    = w0 ^ tWord;
        assign n1    = w1 ^ n0;
        assign n2    = w2 ^ n1;
        assign n3    = w3 ^ n2;

        assign roundKey_d[r] = {n0, n1, n2, n3};
    end

    // Capture the whole schedule each edge; reset clears every round key at once.
    always_ff @(posedge i_aes_key_generation_clk or negedge i_aes_key_generation_rst_n) begin
        if (!i_aes_key_generation_rst_n) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                roundKey_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                roundKey_q[i] <= roundKey_d[i];
            end
        end
    end

    assign o_aes_key_generation_key_0  = roundKey_q[0];
    assign o_aes_key_generation_key_1  = roundKey_q[1];
    assign o_aes_key_generation_key_2  = roundKey_q[2];
    assign o_aes_key_generation_key_3  = roundKey_q[3];
    assign o_aes_key_generation_key_4  = roundKey_q[4];
    assign o_aes_key_generation_key_5  = roundKey_q[5];
    assign o_aes_key_generation_key_6  = roundKey_q[6];
    assign o_aes_key_generation_key_7  = roundKey_q[7];
    assign o_aes_key_generation_key_8  = roundKey_q[8];
    assign o_aes_key_generation_key_9  = roundKey_q[9];
    assign o_aes_key_generation_key_10 = roundKey_q[10];

endmodule

// File: tb/tb_aes_key_generation.sv
// Testbench for aes_key_generation: directed FIPS-197 vectors, latency and
// async-reset behaviour, then random keys against an independent model whose
// S-box is derived from GF(2^8) inversion plus the affine transform.
module tb_aes_key_generation;
    import aes_pkg::*;

    typedef logic [NUM_ROUNDS:0][KEY_W-1:0] keySet_t;

    logic clk;
    logic rst_n;
    aes_key_generation_if keyBus ();

    keySet_t expQ [$];
    int      checksDone   = 0;
    int      checksPassed = 0;
    logic [7:0] modelSbox [0:255];

    localparam logic [KEY_W-1:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [KEY_W-1:0] KEY_ZERO = 128'h0;

    aes_key_generation dut (
        .i_aes_key_generation_clk       (clk),
        .i_aes_key_generation_rst_n     (rst_n),
        .i_aes_key_generation_input_key (keyBus.inputKey),
        .o_aes_key_generation_key_0     (keyBus.roundKey[0]),
        .o_aes_key_generation_key_1     (keyBus.roundKey[1]),
        .o_aes_key_generation_key_2     (keyBus.roundKey[2]),
        .o_aes_key_generation_key_3     (keyBus.roundKey[3]),
        .o_aes_key_generation_key_4     (keyBus.roundKey[4]),
        .o_aes_key_generation_key_5     (keyBus.roundKey[5]),
        .o_aes_key_generation_key_6     (keyBus.roundKey[6]),
        .o_aes_key_generation_key_7     (keyBus.roundKey[7]),
        .o_aes_key_generation_key_8     (keyBus.roundKey[8]),
        .o_aes_key_generation_key_9     (keyBus.roundKey[9]),
        .o_aes_key_generation_key_10    (keyBus.roundKey[10])
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Build the reference S-box mathematically: inverse = x^254, then affine map.
    task automatic buildModelSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h01;
            logic [7:0] xb  = 8'(x);
            for (int k = 0; k < 254; k++) inv = gmul(inv, xb);
            modelSbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                           ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Reference key schedule using the derived S-box.
    function automatic keySet_t expandKey(input logic [KEY_W-1:0] key);
        keySet_t    ks;
        logic [7:0] rc [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        logic [31:0] w [0:3];
        logic [31:0] t;
        ks[0] = key;
        for (int r = 1; r <= 10; r++) begin
            w[0] = ks[r-1][127:96]; w[1] = ks[r-1][95:64];
            w[2] = ks[r-1][63:32];  w[3] = ks[r-1][31:0];
            t = {modelSbox[w[3][23:16]], modelSbox[w[3][15:8]],
                 modelSbox[w[3][7:0]],   modelSbox[w[3][31:24]]};
            t[31:24] = t[31:24] ^ rc[r];
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            ks[r] = {w[0], w[1], w[2], w[3]};
        end
        return ks;
    endfunction

    function automatic keySet_t fipsA1Set();
        keySet_t ks;
        ks[0]  = KEY_A1;
        ks[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        ks[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        ks[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        ks[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        ks[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        ks[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        ks[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        ks[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        ks[9]  = 128'hac7766f319fadc2128d12941575c006e;
        ks[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        return ks;
    endfunction

    function automatic keySet_t zeroKeySet();
        keySet_t ks = expandKey(KEY_ZERO);
        ks[1]  = 128'h62636363626363636263636362636363;
        ks[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        return ks;
    endfunction

    // Compare all eleven outputs against an expected set.
    task automatic checkOutput(input string name, input keySet_t expected);
        keySet_t actual = keyBus.roundKey;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            checksDone++;
            if (actual[i] === expected[i]) begin
                checksPassed++;
            end else begin
                $display("[TB] FAIL %s key_%0d actual=%h expected=%h", name, i, actual[i], expected[i]);
            end
        end
    endtask

    // Drive a key on the falling edge and queue the schedule it must produce.
    task automatic applyStimulus(input logic [KEY_W-1:0] key, input keySet_t expected,
                                 input bit releaseReset);
        @(negedge clk);
        if (releaseReset) rst_n = 1'b1;
        keyBus.inputKey = key;
        expQ.push_back(expected);
    endtask

    // Monitor: each rising edge presents a new schedule; pop and compare just after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                checkOutput("scoreboard", expQ.pop_front());
            end
        end
    end

    keySet_t setA1;
    keySet_t setZero;
    keySet_t setOther;
    keySet_t allZero;

    initial begin
        logic [KEY_W-1:0] rndKey;
        logic [KEY_W-1:0] otherKey;

        buildModelSbox();
        setA1    = fipsA1Set();
        setZero  = zeroKeySet();
        allZero  = '0;
        otherKey = 128'h000102030405060708090a0b0c0d0e0f;
        setOther = expandKey(otherKey);

        rst_n = 1'b0;
        keyBus.inputKey = KEY_A1;
        #13;
        checkOutput("reset_state", allZero);
        @(posedge clk);
        #2;
        checkOutput("reset_held_over_edge", allZero);

        // FIPS-197 A.1 vector, loaded by the first edge after release.
        applyStimulus(KEY_A1, setA1, 1'b1);

        // All-zero key, then latency: old schedule holds until the next edge.
        applyStimulus(KEY_ZERO, setZero, 1'b0);
        #1;
        checkOutput("hold_before_edge", setA1);
        applyStimulus(otherKey, setOther, 1'b0);
        #1;
        checkOutput("hold_zero_before_edge", setZero);
        @(posedge clk);
        #3;
        checkOutput("stable_mid_cycle", setOther);

        // Async reset between edges, held across an edge, then reload.
        applyStimulus(KEY_A1, setA1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_immediate", allZero);
        keyBus.inputKey = otherKey;
        @(posedge clk);
        #2;
        checkOutput("async_reset_held", allZero);
        applyStimulus(otherKey, setOther, 1'b1);

        // Back-to-back alternation of the A.1 and zero keys.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) applyStimulus(KEY_A1, setA1, 1'b0);
            else            applyStimulus(KEY_ZERO, setZero, 1'b0);
        end

        // Random keys against the reference model.
        for (int i = 0; i < 1000; i++) begin
            rndKey = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(rndKey, expandKey(rndKey), 1'b0);
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        if (expQ.size() > 0) begin
            checksDone++;
            $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", expQ.size());
        end

        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
